// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
// Build option: MATMUL_SEQ_SAT_EN selects saturating accumulation in matmul_mac.
package matmul_pkg;

    localparam int IDX_W_DEFAULT   = 4;
    localparam int MAX_DIM_DEFAULT = 15;
    localparam int IDX_W_MAX       = 8;
    localparam int ADDR_W_MAX      = 2 * IDX_W_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } seq_state_t;

    // {row, col} addresses: row occupies the bits above the low idx_w column bits.
    function automatic logic [ADDR_W_MAX-1:0] pack_rc(input logic [IDX_W_MAX-1:0] row,
                                                      input logic [IDX_W_MAX-1:0] col,
                                                      input int idx_w);
        return (ADDR_W_MAX'(row) << idx_w) | ADDR_W_MAX'(col);
    endfunction

    function automatic logic [IDX_W_MAX-1:0] unpack_row(input logic [ADDR_W_MAX-1:0] addr,
                                                        input int idx_w);
        return IDX_W_MAX'(addr >> idx_w);
    endfunction

    function automatic logic [IDX_W_MAX-1:0] unpack_col(input logic [ADDR_W_MAX-1:0] addr,
                                                        input int idx_w);
        logic [ADDR_W_MAX-1:0] mask;
        mask = (ADDR_W_MAX'(1) << idx_w) - ADDR_W_MAX'(1);
        return IDX_W_MAX'(addr & mask);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// 32x32 signed multiply-accumulate; operands arrive one cycle after the issue flags.
// Build option: MATMUL_SEQ_SAT_EN clamps the running sum to the signed 32-bit range.
module matmul_mac
    import matmul_pkg::*;
(
    input  logic        wishbone_clk_i,
    input  logic        wishbone_rst_i,
    input  logic        issue,
    input  logic        issue_first,
    input  logic [31:0] a_rdata,
    input  logic [31:0] b_rdata,
    output logic [31:0] acc_next
);

    logic        valid_reg;
    logic        first_reg;
    logic [31:0] acc_reg;
    logic [31:0] base;
    logic [31:0] step;

`ifdef MATMUL_SEQ_SAT_EN
    logic [63:0] prod;
    logic [64:0] sum;

    always_comb begin
        base = first_reg ? 32'd0 : acc_reg;
        prod = {{32{a_rdata[31]}}, a_rdata} * {{32{b_rdata[31]}}, b_rdata};
        sum  = {{33{base[31]}}, base} + {prod[63], prod};
        // Any disagreement among bits 64..31 means the sum left the 32-bit range.
        if (!sum[64] && (|sum[63:31]))
            step = 32'h7FFF_FFFF;
        else if (sum[64] && !(&sum[63:31]))
            step = 32'h8000_0000;
        else
            step = sum[31:0];
    end
`else
    logic [31:0] prod;

    always_comb begin
        base = first_reg ? 32'd0 : acc_reg;
        prod = a_rdata * b_rdata;
        step = base + prod;
    end
`endif

    assign acc_next = valid_reg ? step : acc_reg;

    always_ff @(posedge wishbone_clk_i) begin
        if (!wishbone_rst_i) begin
            valid_reg <= 1'b0;
            first_reg <= 1'b0;
            acc_reg   <= 32'd0;
        end else begin
            valid_reg <= issue;
            first_reg <= issue_first;
            acc_reg   <= acc_next;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Matrix-multiply control sequencer: validates a job, walks C row-major and drives A/B reads and C writes.
// Build option: MATMUL_SEQ_SAT_EN (saturating accumulation, implemented in matmul_mac).
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int IDX_W   = IDX_W_DEFAULT,
    parameter int MAX_DIM = MAX_DIM_DEFAULT
) (
    input  logic               wishbone_clk_i,
    input  logic               wishbone_rst_i,
    input  logic               start,
    input  logic [IDX_W:0]     dim_m,
    input  logic [IDX_W:0]     dim_ka,
    input  logic [IDX_W:0]     dim_kb,
    input  logic [IDX_W:0]     dim_n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               a_rd_en,
    output logic [2*IDX_W-1:0] a_addr,
    input  logic [31:0]        a_rdata,
    output logic               b_rd_en,
    output logic [2*IDX_W-1:0] b_addr,
    input  logic [31:0]        b_rdata,
    output logic               c_we,
    output logic [2*IDX_W-1:0] c_addr,
    output logic [31:0]        c_wdata
);

    localparam logic [IDX_W:0] MAX_DIM_V = (IDX_W+1)'(MAX_DIM);
    localparam logic [IDX_W:0] ONE       = (IDX_W+1)'(1);

    seq_state_t       state_reg, state_next;
    logic [IDX_W-1:0] i_reg, i_next, j_reg, j_next, k_reg, k_next;
    logic [IDX_W:0]   dim_m_reg, dim_ka_reg, dim_kb_reg, dim_n_reg;
    logic             err_reg, err_next;
    logic             rd_en_reg, rd_first_reg, c_we_reg;
    logic [2*IDX_W-1:0] a_addr_reg, b_addr_reg, c_addr_reg;
    logic [31:0]      c_wdata_reg, acc_next;
    logic             job_bad, last_i, last_j, last_k;

    function automatic logic [2*IDX_W-1:0] rc(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
        return (2*IDX_W)'(pack_rc(IDX_W_MAX'(r), IDX_W_MAX'(c), IDX_W));
    endfunction

    assign job_bad = (dim_m_reg == '0) || (dim_ka_reg == '0) || (dim_kb_reg == '0) ||
                     (dim_n_reg == '0) || (dim_m_reg > MAX_DIM_V) || (dim_ka_reg > MAX_DIM_V) ||
                     (dim_kb_reg > MAX_DIM_V) || (dim_n_reg > MAX_DIM_V) || (dim_ka_reg != dim_kb_reg);
    assign last_i  = ({1'b0, i_reg} == dim_m_reg - ONE);
    assign last_j  = ({1'b0, j_reg} == dim_n_reg - ONE);
    assign last_k  = ({1'b0, k_reg} == dim_ka_reg - ONE);

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: if (start) begin
                state_next = S_CHECK;
                err_next   = 1'b0;
            end
            S_CHECK: if (job_bad) begin
                err_next   = 1'b1;
                state_next = S_DONE;
            end else begin
                i_next     = '0;
                j_next     = '0;
                k_next     = '0;
                state_next = S_RUN;
            end
            S_RUN: if (last_k) state_next = S_DRAIN;
                   else        k_next     = k_reg + 1'b1;
            S_DRAIN: state_next = S_WRITE;
            S_WRITE: begin
                k_next     = '0;
                state_next = S_RUN;
                if (!last_j) begin
                    j_next = j_reg + 1'b1;
                end else if (!last_i) begin
                    j_next = '0;
                    i_next = i_reg + 1'b1;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output registers load from next-state values so strobes line up with the state they belong to.
    always_ff @(posedge wishbone_clk_i) begin
        if (!wishbone_rst_i) begin
            state_reg    <= S_IDLE;
            i_reg        <= '0;
            j_reg        <= '0;
            k_reg        <= '0;
            err_reg      <= 1'b0;
            dim_m_reg    <= '0;
            dim_ka_reg   <= '0;
            dim_kb_reg   <= '0;
            dim_n_reg    <= '0;
            rd_en_reg    <= 1'b0;
            rd_first_reg <= 1'b0;
            c_we_reg     <= 1'b0;
            a_addr_reg   <= '0;
            b_addr_reg   <= '0;
            c_addr_reg   <= '0;
            c_wdata_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            i_reg        <= i_next;
            j_reg        <= j_next;
            k_reg        <= k_next;
            err_reg      <= err_next;
            if (state_reg == S_IDLE && start) begin
                dim_m_reg  <= dim_m;
                dim_ka_reg <= dim_ka;
                dim_kb_reg <= dim_kb;
                dim_n_reg  <= dim_n;
            end
            rd_en_reg    <= (state_next == S_RUN);
            rd_first_reg <= (state_next == S_RUN) && (k_next == '0);
            c_we_reg     <= (state_next == S_WRITE);
            a_addr_reg   <= rc(i_next, k_next);
            b_addr_reg   <= rc(k_next, j_next);
            c_addr_reg   <= rc(i_next, j_next);
            if (state_next == S_WRITE)
                c_wdata_reg <= acc_next;
        end
    end

    matmul_mac u_mac (
        .wishbone_clk_i (wishbone_clk_i),
        .wishbone_rst_i (wishbone_rst_i),
        .issue          (rd_en_reg),
        .issue_first    (rd_first_reg),
        .a_rdata        (a_rdata),
        .b_rdata        (b_rdata),
        .acc_next       (acc_next)
    );

    assign busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done    = (state_reg == S_DONE);
    assign err     = done && err_reg;
    assign a_rd_en = rd_en_reg;
    assign b_rd_en = rd_en_reg;
    assign a_addr  = a_addr_reg;
    assign b_addr  = b_addr_reg;
    assign c_we    = c_we_reg;
    assign c_addr  = c_addr_reg;
    assign c_wdata = c_wdata_reg;

endmodule
